// File: rtl/sipo_capture.sv
// sipo_capture: serial-in/parallel-out deserializer with an output FIFO.
// One bit is sampled per vga_clk while display_area is high, MSB first.
// Each completed WIDTH-bit word is queued with a valid/ready handshake. A word
// cut short by display_area falling is flushed zero-padded, or dropped.
module sipo_capture #(
  parameter int WIDTH       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter bit PAD_PARTIAL = 1'b1
) (
  input  logic                          vga_clk,
  input  logic                          reset,
  input  logic                          display_area,
  input  logic                          serial_input,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_partial,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   shift_in;

  logic               push;
  logic [WIDTH-1:0]   push_data;
  logic               push_partial;
  logic               flush;

  logic [WIDTH-1:0]   mem_data    [FIFO_DEPTH];
  logic               mem_partial [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               empty, full, pop, wr_en, drop;

  assign shift_in = {shreg[WIDTH-2:0], serial_input};

  // State register: IDLE means no bits of a word are held.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a sampled bit starts/continues a word; the last bit or a
  // display_area drop returns to IDLE.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (display_area) state_nxt = SHIFT;
      SHIFT: if (!display_area || cnt == LAST_BIT) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: complete word on the last bit, or padded flush on a drop.
  always_comb begin
    push         = 1'b0;
    push_data    = '0;
    push_partial = 1'b0;
    flush        = 1'b0;
    if (display_area) begin
      if (cnt == LAST_BIT) begin
        push      = 1'b1;
        push_data = shift_in;
      end
    end else if (state == SHIFT) begin
      // The k received bits sit in shreg[k-1:0]; left-align them, zero below.
      flush        = 1'b1;
      push         = PAD_PARTIAL;
      push_data    = shreg << (WIDTH - int'(cnt));
      push_partial = 1'b1;
    end
  end

  // Bit counter and shift register.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (display_area) begin
      shreg <= shift_in;
      cnt   <= (cnt == LAST_BIT) ? '0 : cnt + CNT_W'(1);
    end else if (flush) begin
      cnt   <= '0;
      shreg <= '0;
    end
  end

  // FIFO control: a push while full only lands if the head leaves on the same edge.
  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);
  assign pop   = !empty && out_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // FIFO storage write.
  // NOTE: the storage array has no reset; the outputs are forced to zero while
  // empty, so stale contents are never observable.
  always_ff @(posedge vga_clk) begin
    if (wr_en) begin
      mem_data[wr_ptr]    <= push_data;
      mem_partial[wr_ptr] <= push_partial;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !pop)      level <= level + LVL_W'(1);
      else if (!wr_en && pop) level <= level - LVL_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  assign out_valid   = !empty;
  assign out_data    = empty ? '0   : mem_data[rd_ptr];
  assign out_partial = empty ? 1'b0 : mem_partial[rd_ptr];
  assign fifo_level  = level;

endmodule

// File: tb/tb_sipo_capture.sv
// Testbench for sipo_capture: directed vectors, scoreboard queue filled by the
// stimulus and drained by an independent monitor on each accepted output word.
module tb_sipo_capture;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b0;
  logic       display_area = 1'b0;
  logic       serial_input = 1'b0;
  logic       out_ready = 1'b0;
  logic       np_ready = 1'b1;

  logic       out_valid, out_partial, overflow;
  logic [7:0] out_data;
  logic [2:0] fifo_level;

  logic       np_valid, np_partial, np_overflow;
  logic [7:0] np_data;
  logic [2:0] np_level;

  typedef struct packed {
    logic [7:0] data;
    logic       partial;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 vga_clk = ~vga_clk;

  sipo_capture #(.WIDTH(8), .FIFO_DEPTH(4), .PAD_PARTIAL(1'b1)) dut (
    .vga_clk(vga_clk), .reset(reset), .display_area(display_area),
    .serial_input(serial_input), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_partial(out_partial), .fifo_level(fifo_level),
    .overflow(overflow)
  );

  // Discarding variant, observed only for the partial-word case.
  sipo_capture #(.WIDTH(8), .FIFO_DEPTH(4), .PAD_PARTIAL(1'b0)) dut_np (
    .vga_clk(vga_clk), .reset(reset), .display_area(display_area),
    .serial_input(serial_input), .out_ready(np_ready), .out_valid(np_valid),
    .out_data(np_data), .out_partial(np_partial), .fifo_level(np_level),
    .overflow(np_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  // Drive the first n bits of w, MSB first, one per edge.
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      display_area = 1'b1;
      serial_input = w[7-i];
      tick();
    end
  endtask

  task automatic expect_word(input logic [7:0] d, input logic p);
    sb_q.push_back({d, p});
  endtask

  // Wait (bounded) for the FIFO to drain with out_ready held high.
  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 20) begin
      tick();
      n++;
    end
    check({name, "_drain_timeout"}, 32'(out_valid), 32'd0);
    check({name, "_level_empty"}, 32'(fifo_level), 32'd0);
    check({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: every word accepted by the consumer must match the queue head.
  always @(negedge vga_clk) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected: got %0h expected no word", out_data);
      end else begin
        e = sb_q.pop_front();
        check("mon_data", 32'(out_data), 32'(e.data));
        check("mon_partial", 32'(out_partial), 32'(e.partial));
      end
    end
  end

  initial begin
    // Reset state.
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_partial", 32'(out_partial), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;

    // 1: single word 1,0,1,0,0,1,0,1 = A5, visible right after its last edge.
    out_ready = 1'b1;
    expect_word(8'hA5, 1'b0);
    send_bits(8'hA5, 8);
    display_area = 1'b0;
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'hA5);
    check("t1_partial", 32'(out_partial), 32'd0);
    tick();
    check("t1_popped", 32'(out_valid), 32'd0);

    // 2: loopback of a serializer repeating 3C; the 1-cycle display_area delay
    // aligns the window with the serial stream, so bits arrive back to back.
    for (int b = 0; b < 3; b++) begin
      expect_word(8'h3C, 1'b0);
      send_bits(8'h3C, 8);
      check("t2_valid_nogap", 32'(out_valid), 32'd1);
      check("t2_data", 32'(out_data), 32'h3C);
    end
    display_area = 1'b0;
    tick();

    // 3: partial flush of 1,1,0 -> C0 padded; the discarding variant stays empty.
    expect_word(8'hC0, 1'b1);
    send_bits(8'hC0, 3);
    display_area = 1'b0;
    tick();
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_data", 32'(out_data), 32'hC0);
    check("t3_partial", 32'(out_partial), 32'd1);
    check("t3_np_valid", 32'(np_valid), 32'd0);
    tick();
    check("t3_np_valid_later", 32'(np_valid), 32'd0);
    check("t3_np_level", 32'(np_level), 32'd0);
    check("t3_popped", 32'(out_valid), 32'd0);

    // 4: backpressure, five words into a four-entry FIFO.
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) expect_word(8'(v), 1'b0);
      send_bits(8'(v), 8);
    end
    display_area = 1'b0;
    tick();
    check("t4_level", 32'(fifo_level), 32'd4);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_head_hold", 32'(out_data), 32'h01);
    drain("t4");
    check("t4_overflow_sticky", 32'(overflow), 32'd1);

    // 6: reset four bits into a word while the FIFO holds data.
    out_ready = 1'b0;
    expect_word(8'h77, 1'b0);
    send_bits(8'h77, 8);
    send_bits(8'h5A, 4);
    reset = 1'b0;
    display_area = 1'b0;
    #1;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_data", 32'(out_data), 32'd0);
    check("t6_partial", 32'(out_partial), 32'd0);
    check("t6_level", 32'(fifo_level), 32'd0);
    check("t6_overflow", 32'(overflow), 32'd0);
    sb_q.delete();
    tick();
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    expect_word(8'h5A, 1'b0);
    send_bits(8'h5A, 8);
    display_area = 1'b0;
    check("t6_valid_after", 32'(out_valid), 32'd1);
    check("t6_data_after", 32'(out_data), 32'h5A);
    tick();

    // 5: FIFO full, a pop coincides with the edge completing the next word.
    out_ready = 1'b0;
    for (int v = 8'h11; v <= 8'h14; v++) begin
      expect_word(8'(v), 1'b0);
      send_bits(8'(v), 8);
    end
    display_area = 1'b0;
    tick();
    check("t5_level_full", 32'(fifo_level), 32'd4);
    expect_word(8'h15, 1'b0);
    send_bits(8'h15, 7);
    display_area = 1'b1;
    serial_input = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    display_area = 1'b0;
    check("t5_level", 32'(fifo_level), 32'd4);
    check("t5_overflow", 32'(overflow), 32'd0);
    check("t5_head", 32'(out_data), 32'h12);
    drain("t5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
